// File: rtl/fsm_down_step.sv
// fsm_down_step: synchronised rising-edge down counter with wrap borrow, preload and zero flag; define FSM_DOWN_REPEAT_EN for hold-to-repeat stepping
module fsm_down_step #(
   parameter int WIDTH = 2,
   parameter int MAX_VAL = 3,
   parameter int SYNC_STAGES = 2,
   parameter int REPEAT_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             borrow,
   output logic             zero
);
   typedef enum logic {ARMED, HELD} state_t;
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
   state_t state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic sync_in, step, rpt_hit;
   logic [WIDTH-1:0] nxt, ld_val;
   assign sync_in = sync_q[SYNC_STAGES-1];
   assign ld_val = load_val > MAX ? MAX : load_val;
`ifdef FSM_DOWN_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rpt_cnt;
   assign rpt_hit = state == HELD && sync_in && rpt_cnt == RPT_LAST;
`else
   assign rpt_hit = 1'b0;
`endif
   // metastability chain for the asynchronous step request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], in};
   end
   // step on the synchronised rising edge (or repeat tick), then next count with load taking priority
   always_comb begin
      step = (state == ARMED && sync_in) || rpt_hit;
      nxt = load ? ld_val : step ? (out == '0 ? MAX : out - 1'b1) : out;
   end
   // edge FSM, repeat counter and registered count outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARMED;
         out    <= '0;
         borrow <= 1'b0;
         zero   <= 1'b1;
`ifdef FSM_DOWN_REPEAT_EN
         rpt_cnt <= '0;
`endif
      end else begin
         state  <= sync_in ? HELD : ARMED;
         out    <= nxt;
         borrow <= !load && step && out == '0;
         zero   <= nxt == '0;
`ifdef FSM_DOWN_REPEAT_EN
         rpt_cnt <= (load || rpt_hit || !(state == HELD && sync_in)) ? '0 : rpt_cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_fsm_down_step.sv
// tb_fsm_down_step: randomized scoreboard bench for fsm_down_step against a step-rule reference model
module tb_fsm_down_step;
   localparam int W = 2, MX = 3, SS = 2, RC = 8;
   typedef struct packed {logic [W-1:0] o; logic b; logic z;} exp_t;
   localparam exp_t RST_E = '{o: '0, b: 1'b0, z: 1'b1};
   logic clk = 0, rst = 1, in = 0, load = 0;
   logic [W-1:0] load_val = '0, out;
   logic borrow, zero;
   logic in2 = 0, load2 = 0;
   logic [W-1:0] lv2 = '0, out2;
   logic borrow2, zero2;
   int total = 0, bad = 0;
   exp_t exp_q[$];
   bit hist[$];
   int m_out = 0, since = 0;
   bit m_sh, m_st, m_b;

   fsm_down_step #(.WIDTH(W), .MAX_VAL(MX), .SYNC_STAGES(SS), .REPEAT_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .in(in), .load(load), .load_val(load_val),
      .out(out), .borrow(borrow), .zero(zero));
   fsm_down_step #(.WIDTH(W), .MAX_VAL(2), .SYNC_STAGES(SS), .REPEAT_CYCLES(RC)) dut2 (
      .clk(clk), .rst(rst), .in(in2), .load(load2), .load_val(lv2),
      .out(out2), .borrow(borrow2), .zero(zero2));

   always #5 clk = ~clk;

   task automatic check(string n, exp_t a, exp_t e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s @%0t: got out=%0d borrow=%0b zero=%0b, want out=%0d borrow=%0b zero=%0b",
                  n, $time, a.o, a.b, a.z, e.o, e.b, e.z);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // reference model: a step is a 0->1 of the input stream delayed SS edges; load overrides
   always @(posedge clk) begin
      if (rst) begin
         m_out = 0;
         since = 0;
         hist.delete();
         repeat (SS + 1) hist.push_back(1'b0);
      end else begin
         m_sh = hist[SS-1];
         m_st = m_sh && !hist[SS];
`ifdef FSM_DOWN_REPEAT_EN
         if (m_sh) begin
            since = m_st ? 0 : since + 1;
            m_st = since % RC == 0;
         end
         if (load) since = 0;
`endif
         m_b = 1'b0;
         if (load) m_out = int'(load_val) > MX ? MX : int'(load_val);
         else if (m_st) begin
            m_b = m_out == 0;
            m_out = m_out == 0 ? MX : m_out - 1;
         end
         exp_q.push_back('{o: W'(m_out), b: m_b, z: m_out == 0});
         hist.push_front(in);
         void'(hist.pop_back());
      end
   end

   // monitor: the count outputs are presented every cycle, compared mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         check("reset_state", {out, borrow, zero}, RST_E);
      end else if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty @%0t: got no expectation, want one per cycle", $time);
      end else check("scoreboard", {out, borrow, zero}, exp_q.pop_front());
   end

   initial begin
      cyc(3);
      rst = 0;
      cyc(10);
      in = 1;
      cyc(5);
      in = 0;
      cyc(4);
      for (int i = 0; i < 4; i++) begin
         in = 1;
         cyc(2);
         in = 0;
         cyc(3);
      end
      in = 1;
      cyc(2);
      load = 1;
      load_val = 2'd2;
      cyc(1);
      load = 0;
      cyc(3);
      in = 0;
      cyc(3);
      in = 1;
      cyc(4);
      #3 rst = 1;
      #1 check("async_reset", {out, borrow, zero}, RST_E);
      cyc(2);
      rst = 0;
      cyc(5);
      in = 0;
      cyc(3);
      in = 1;
      cyc(30);
      in = 0;
      cyc(4);
      for (int i = 0; i < 80; i++) begin
         in = 1'($urandom);
         load = $urandom_range(0, 7) == 0;
         load_val = W'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            #3 rst = 1;
            cyc(2);
            rst = 0;
         end
         cyc($urandom_range(1, 12));
      end
      load = 0;
      in = 0;
      cyc(4);
      load2 = 1;
      lv2 = 2'd3;
      cyc(1);
      check("clamp_3_to_2", {out2, borrow2, zero2}, '{o: 2'd2, b: 1'b0, z: 1'b0});
      lv2 = 2'd1;
      cyc(1);
      check("load_1", {out2, borrow2, zero2}, '{o: 2'd1, b: 1'b0, z: 1'b0});
      lv2 = 2'd0;
      cyc(1);
      load2 = 0;
      check("load_0", {out2, borrow2, zero2}, '{o: 2'd0, b: 1'b0, z: 1'b1});
      in2 = 1;
      cyc(3);
      check("wrap_max2", {out2, borrow2, zero2}, '{o: 2'd2, b: 1'b1, z: 1'b0});
      cyc(1);
      check("borrow_one_cycle", {out2, borrow2, zero2}, '{o: 2'd2, b: 1'b0, z: 1'b0});
      in2 = 0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by %0t, want finish", $time);
      $fatal(1);
   end
endmodule
